mux_n_to_1_rr: RTL and testbench

MUX_N_TO_1_RR -- requirements
Module: mux_n_to_1_rr

---
 rtl/mux_n_to_1_rr_pkg.sv | 14 +
 rtl/mux_n_to_1_rr_if.sv | 29 ++
 rtl/mux_n_to_1_rr_arb.sv | 49 ++++
 rtl/mux_n_to_1_rr.sv | 81 ++++++++
 tb/tb_mux_n_to_1_rr.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_to_1_rr_pkg.sv
// mux_pkg: shared mode encodings and helpers for the N:1 mux.
// Used by the arbiter, the interface and the top level.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mux_n_to_1_rr_if.sv
// mux_n_to_1_rr_if: input channels, mode/sel and output stream.
// slave = mux side, master = producer/consumer side.
interface mux_n_to_1_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = $clog2(CH)
);
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  mode_e               mode;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_ch;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_n_to_1_rr_arb.sv
// rr_arbiter: valid_i, ptr_i, mode_i, sel_i -> grant_o (one-hot),
// idx_o (granted index), any_o (some channel granted).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   valid_i,
  input  logic [SELW-1:0] ptr_i,
  input  mode_e           mode_i,
  input  logic [SELW-1:0] sel_i,
  output logic [CH-1:0]   grant_o,
  output logic [SELW-1:0] idx_o,
  output logic            any_o
);

  // Rotated view: bit i is channel (ptr+i) mod CH.
  logic [2*CH-1:0] dbl;
  assign dbl = {valid_i, valid_i} >> ptr_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    unique case (mode_i)
      MODE_FIXED: begin
        // sel >= CH never matches, so no grant.
        for (int k = 0; k < CH; k++) begin
          if (k == int'(sel_i) && valid_i[k]) begin
            grant_o[k] = 1'b1;
            idx_o      = SELW'(k);
            any_o      = 1'b1;
          end
        end
      end
      MODE_RR: begin
        for (int i = 0; i < CH; i++) begin
          if (!any_o && dbl[i]) begin
            any_o   = 1'b1;
            idx_o   = SELW'((int'(ptr_i) + i) % CH);
            grant_o = CH'(1) << ((int'(ptr_i) + i) % CH);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// mux_n_to_1_rr: CH:1 stream mux, fixed or round-robin, 1-cycle reg.
// Ports: clk, rst_n (async low), bus (mux_n_to_1_rr_if.slave).
module mux_n_to_1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = $clog2(CH)
) (
  input logic            clk,
  input logic            rst_n,
  mux_n_to_1_rr_if.slave bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [CH-1:0]    grant;
  logic [SELW-1:0]  idx;
  logic             any;
  logic             open;
  logic [WIDTH-1:0] data_sel;

  rr_arbiter #(.CH(CH), .SELW(SELW)) u_arb (
    .valid_i (bus.in_valid),
    .ptr_i   (ptr_q),
    .mode_i  (bus.mode),
    .sel_i   (bus.sel),
    .grant_o (grant),
    .idx_o   (idx),
    .any_o   (any)
  );

  assign open = !out_valid_q || bus.out_ready;

  // Gated by rst_n so nothing is accepted while in reset.
  assign bus.in_ready = (rst_n && open) ? grant : '0;

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < CH; k++) begin
      if (grant[k]) data_sel = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (open) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = data_sel;
        out_ch_d   = idx;
        ptr_d      = SELW'(wrap_inc(int'(idx), CH));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb_mux_n_to_1_rr: directed checks of mux_n_to_1_rr, CH=4, WIDTH=8.
// SELW=3 so that out-of-range sel values can be driven.
module tb_mux_n_to_1_rr;
  import mux_pkg::*;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 3;

  typedef struct {
    int         ch;
    logic [W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux_n_to_1_rr_if #(.WIDTH(W), .CH(N), .SELW(S)) bus();

  mux_n_to_1_rr #(.WIDTH(W), .CH(N), .SELW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] d [N];
  ent_t sbq [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = d[k];
  endtask

  function automatic logic [N-1:0] model_grant(
    logic [N-1:0] v, bit rr, int s, int p);
    logic [N-1:0] one;
    one = 1;
    if (!rr) begin
      if (s < N && ((v >> s) & one) != 0) return one << s;
      return '0;
    end
    for (int i = 0; i < N; i++) begin
      if (((v >> ((p + i) % N)) & one) != 0)
        return one << ((p + i) % N);
    end
    return '0;
  endfunction

  initial begin
    logic [N-1:0] eg;
    bit   mv;
    bit   open_m;
    int   mptr;
    int   gch;
    ent_t e;

    d[0] = 8'h10; d[1] = 8'hA5; d[2] = 8'h12; d[3] = 8'h13;
    load();
    bus.in_valid  = 4'hF;
    bus.mode      = MODE_RR;
    bus.sel       = '0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_ch", bus.out_ch, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1;

    // Fairness: channel 0 first, then rotate.
    for (int i = 0; i < 8; i++) begin
      chk("rr_rdy", bus.in_ready, 1 << (i % N));
      tick();
      chk("rr_ov", bus.out_valid, 1);
      chk("rr_ch", bus.out_ch, i % N);
      chk("rr_dat", bus.out_data, d[i % N]);
    end
    bus.in_valid = '0;
    tick();
    chk("idle_ov", bus.out_valid, 0);

    // Skip/wrap from ptr=3 with valids 0101.
    bus.in_valid = 4'b0100;
    #1 chk("pre_rdy", bus.in_ready, 4'b0100);
    tick();
    bus.in_valid = 4'b0101;
    for (int j = 0; j < 3; j++) begin
      #1 chk("wrap_rdy", bus.in_ready, (j == 1) ? 4'b0100 : 4'b0001);
      tick();
      chk("wrap_ch", bus.out_ch, (j == 1) ? 2 : 0);
    end
    bus.in_valid = 4'hF;
    #1 chk("ptr1_rdy", bus.in_ready, 4'b0010);

    // Backpressure holding A5.
    tick();
    chk("bp_dat0", bus.out_data, 8'hA5);
    bus.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1 chk("bp_rdy", bus.in_ready, 0);
      tick();
      chk("bp_dat", bus.out_data, 8'hA5);
      chk("bp_ov", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_rel", bus.in_ready, 4'b0100);
    tick();
    chk("bp_next", bus.out_data, 8'h12);
    bus.in_valid = '0;
    tick();
    chk("bp_idle", bus.out_valid, 0);

    // Fixed mode.
    bus.mode = MODE_FIXED;
    bus.sel = 3'd2;
    bus.in_valid = 4'b1011;
    #1 chk("fx_none", bus.in_ready, 0);
    tick();
    chk("fx_ov0", bus.out_valid, 0);
    bus.in_valid = 4'b0100;
    #1 chk("fx_rdy", bus.in_ready, 4'b0100);
    tick();
    chk("fx_ch", bus.out_ch, 2);
    chk("fx_dat", bus.out_data, 8'h12);
    bus.sel = 3'd5;
    bus.in_valid = 4'hF;
    #1 chk("fx5_rdy", bus.in_ready, 0);
    tick();
    chk("fx5_ov", bus.out_valid, 0);
    tick();
    chk("fx5_ov2", bus.out_valid, 0);
    bus.sel = 3'd4;
    #1 chk("fx4_rdy", bus.in_ready, 0);
    bus.sel = 3'd3;
    #1 chk("fx3_rdy", bus.in_ready, 4'b1000);
    tick();
    chk("fx3_ch", bus.out_ch, 3);

    // Mode toggling every cycle against a scoreboard.
    mv = 1'b1;
    mptr = 0;
    e.ch = 3;
    e.data = 8'h13;
    sbq.push_back(e);
    for (int c = 0; c < 60; c++) begin
      bus.mode = (c % 2 == 1) ? MODE_RR : MODE_FIXED;
      bus.sel = S'($urandom_range(0, 5));
      bus.in_valid = N'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) d[k] = W'($urandom);
      load();
      #1;
      if (mv && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_ch", bus.out_ch, e.ch);
          chk("sb_dat", bus.out_data, e.data);
        end
      end
      chk("sb_ov", bus.out_valid, mv);
      open_m = !mv || bus.out_ready;
      eg = open_m ? model_grant(bus.in_valid, c % 2 == 1,
                                int'(bus.sel), mptr) : '0;
      chk("sb_rdy", bus.in_ready, eg);
      if (open_m) begin
        mv = (eg != 0);
        if (eg != 0) begin
          gch = 0;
          for (int k = 0; k < N; k++) if (eg[k]) gch = k;
          e.ch = gch;
          e.data = d[gch];
          sbq.push_back(e);
          mptr = (gch + 1) % N;
        end
      end
      tick();
    end
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    #1;
    if (mv) begin
      e = sbq.pop_front();
      chk("dr_ch", bus.out_ch, e.ch);
      chk("dr_dat", bus.out_data, e.data);
    end
    tick();
    chk("dr_ov", bus.out_valid, 0);
    chk("sb_left", sbq.size(), 0);

    // Asynchronous reset mid-stream.
    bus.mode = MODE_RR;
    bus.in_valid = 4'b0010;
    d[1] = 8'h5A;
    load();
    tick();
    chk("mr_ch", bus.out_ch, 1);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov", bus.out_valid, 0);
    chk("mr_och", bus.out_ch, 0);
    chk("mr_dat", bus.out_data, 0);
    chk("mr_rdy", bus.in_ready, 0);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("post_rdy", bus.in_ready, 4'b0001);
    tick();
    chk("post_ch", bus.out_ch, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
